// File: rtl/aead_bus_sequencer.sv
// rtl/aead_bus_sequencer.sv - bus sequencer that drives one AEAD block operation on a register-mapped engine
//
// Purpose: on start, writes key (optional), nonce, mode and data block to the
// engine, pulses init, polls status until valid or timeout, then reads back
// the data block and tag.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 single-cycle operation request (ignored while busy)
//   key_load              1 = write key words this operation
//   encdec                mode bit forwarded to engine register 0x0a
//   key, nonce, block_in  operation operands, latched on accepted start
//   busy, done, error     status: in progress, completion pulse, poll timeout
//   block_out, tag        engine results captured during the operation
//   tag_ok                tag_ok status bit captured at the accepting poll
//   bus_cs, bus_we        engine bus strobes (registered)
//   bus_address           engine register address (registered)
//   bus_write_data        engine write data (registered)
//   bus_read_data         engine read data, valid the cycle after a read
module aead_bus_sequencer #(
    parameter int unsigned TIMEOUT_POLLS = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         key_load,
    input  logic         encdec,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [511:0] block_out,
    output logic [127:0] tag,
    output logic         tag_ok,
    output logic         bus_cs,
    output logic         bus_we,
    output logic [7:0]   bus_address,
    output logic [511:0] bus_write_data,
    input  logic [511:0] bus_read_data
);

    typedef enum logic [3:0] {
        IDLE,
        WR_KEY,
        WR_NONCE,
        WR_MODE,
        WR_DATA,
        INIT_SET,
        INIT_CLR,
        POLL_REQ,
        POLL_CHK,
        RD_DATA,
        RD_TAG,
        CAP_TAG,
        DONE_ST
    } state_t;

    // A limit beyond the counter range can never be reached by a saturating
    // 16-bit counter; clamp it so the compare stays in 16 bits.
    localparam logic [15:0] POLL_LIMIT =
        (TIMEOUT_POLLS > 32'd65535) ? 16'hffff : TIMEOUT_POLLS[15:0];

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [15:0]    poll_cnt_q, poll_cnt_d;
    logic [15:0]    poll_cnt_inc;
    logic [255:0]   key_q, key_d;
    logic [95:0]    nonce_q, nonce_d;
    logic [511:0]   blk_q, blk_d;
    logic           encdec_q, encdec_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [511:0]   block_out_q, block_out_d;
    logic [127:0]   tag_q, tag_d;
    logic           tag_ok_q, tag_ok_d;
    logic           bus_cs_q, bus_cs_d;
    logic           bus_we_q, bus_we_d;
    logic [7:0]     bus_address_q, bus_address_d;
    logic [511:0]   bus_write_data_q, bus_write_data_d;
    logic [31:0]    key_word;
    logic [31:0]    nonce_word;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        poll_cnt_d   = poll_cnt_q;
        key_d        = key_q;
        nonce_d      = nonce_q;
        blk_d        = blk_q;
        encdec_d     = encdec_q;
        error_d      = error_q;
        block_out_d  = block_out_q;
        tag_d        = tag_q;
        tag_ok_d     = tag_ok_q;
        poll_cnt_inc = (poll_cnt_q == 16'hffff) ? poll_cnt_q : poll_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d      = key;
                    nonce_d    = nonce;
                    blk_d      = block_in;
                    encdec_d   = encdec;
                    error_d    = 1'b0;
                    poll_cnt_d = 16'd0;
                    idx_d      = 3'd0;
                    state_d    = key_load ? WR_KEY : WR_NONCE;
                end
            end
            WR_KEY: begin
                if (idx_q == 3'd7) begin
                    idx_d   = 3'd0;
                    state_d = WR_NONCE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            WR_NONCE: begin
                if (idx_q == 3'd2) begin
                    idx_d   = 3'd0;
                    state_d = WR_MODE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            WR_MODE:  state_d = WR_DATA;
            WR_DATA:  state_d = INIT_SET;
            INIT_SET: state_d = INIT_CLR;
            INIT_CLR: state_d = POLL_REQ;
            POLL_REQ: state_d = POLL_CHK;
            POLL_CHK: begin
                // Status word: bit0 ready, bit1 valid, bit2 tag_ok.
                if (bus_read_data[1]) begin
                    tag_ok_d = bus_read_data[2];
                    state_d  = RD_DATA;
                end else begin
                    poll_cnt_d = poll_cnt_inc;
                    if (poll_cnt_inc >= POLL_LIMIT) begin
                        error_d = 1'b1;
                        state_d = DONE_ST;
                    end else begin
                        state_d = POLL_REQ;
                    end
                end
            end
            RD_DATA: state_d = RD_TAG;
            RD_TAG: begin
                // Read data of the 0x30 access issued in RD_DATA arrives now.
                block_out_d = bus_read_data;
                state_d     = CAP_TAG;
            end
            CAP_TAG: begin
                tag_d   = bus_read_data[127:0];
                state_d = DONE_ST;
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus registers are loaded with the access belonging to the state
        // being entered, so each state's access is on the bus while in it.
        // Operands come from the _d side so the first write already sees
        // the values latched by the accepting start.
        key_word         = key_d[{~idx_d, 5'b00000} +: 32];
        nonce_word       = nonce_d[{idx_d[1:0], 5'b00000} +: 32];
        done_d           = (state_d == DONE_ST);
        bus_cs_d         = 1'b0;
        bus_we_d         = 1'b0;
        bus_address_d    = 8'h00;
        bus_write_data_d = 512'd0;

        case (state_d)
            WR_KEY: begin
                bus_cs_d         = 1'b1;
                bus_we_d         = 1'b1;
                bus_address_d    = 8'h10 + {5'd0, idx_d};
                bus_write_data_d = {480'd0, key_word};
            end
            WR_NONCE: begin
                bus_cs_d         = 1'b1;
                bus_we_d         = 1'b1;
                bus_address_d    = 8'h20 + {5'd0, idx_d};
                bus_write_data_d = {480'd0, nonce_word};
            end
            WR_MODE: begin
                bus_cs_d         = 1'b1;
                bus_we_d         = 1'b1;
                bus_address_d    = 8'h0a;
                bus_write_data_d = {511'd0, encdec_d};
            end
            WR_DATA: begin
                bus_cs_d         = 1'b1;
                bus_we_d         = 1'b1;
                bus_address_d    = 8'h30;
                bus_write_data_d = blk_d;
            end
            INIT_SET: begin
                bus_cs_d         = 1'b1;
                bus_we_d         = 1'b1;
                bus_address_d    = 8'h08;
                bus_write_data_d = 512'd1;
            end
            INIT_CLR: begin
                bus_cs_d      = 1'b1;
                bus_we_d      = 1'b1;
                bus_address_d = 8'h08;
            end
            POLL_REQ: begin
                bus_cs_d      = 1'b1;
                bus_address_d = 8'h09;
            end
            RD_DATA: begin
                bus_cs_d      = 1'b1;
                bus_address_d = 8'h30;
            end
            RD_TAG: begin
                bus_cs_d      = 1'b1;
                bus_address_d = 8'h40;
            end
            default: begin
                bus_cs_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            idx_q            <= 3'd0;
            poll_cnt_q       <= 16'd0;
            key_q            <= 256'd0;
            nonce_q          <= 96'd0;
            blk_q            <= 512'd0;
            encdec_q         <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            block_out_q      <= 512'd0;
            tag_q            <= 128'd0;
            tag_ok_q         <= 1'b0;
            bus_cs_q         <= 1'b0;
            bus_we_q         <= 1'b0;
            bus_address_q    <= 8'h00;
            bus_write_data_q <= 512'd0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            poll_cnt_q       <= poll_cnt_d;
            key_q            <= key_d;
            nonce_q          <= nonce_d;
            blk_q            <= blk_d;
            encdec_q         <= encdec_d;
            done_q           <= done_d;
            error_q          <= error_d;
            block_out_q      <= block_out_d;
            tag_q            <= tag_d;
            tag_ok_q         <= tag_ok_d;
            bus_cs_q         <= bus_cs_d;
            bus_we_q         <= bus_we_d;
            bus_address_q    <= bus_address_d;
            bus_write_data_q <= bus_write_data_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign error          = error_q;
    assign block_out      = block_out_q;
    assign tag            = tag_q;
    assign tag_ok         = tag_ok_q;
    assign bus_cs         = bus_cs_q;
    assign bus_we         = bus_we_q;
    assign bus_address    = bus_address_q;
    assign bus_write_data = bus_write_data_q;

endmodule

// File: doc/aead_bus_sequencer.md
AEAD_BUS_SEQUENCER -- requirements
Module: aead_bus_sequencer

Interface
REQ-001 Parameter TIMEOUT_POLLS, default 1024: number of not-valid status polls tolerated before the operation aborts with an error.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to run one AEAD block operation.
REQ-005 key_load  input  1  1 means key words are written this operation; 0 means key writes are skipped.
REQ-006 encdec  input  1  mode bit forwarded to the engine mode register.
REQ-007 key  input  256  key; word i is key[255-32i -: 32].
REQ-008 nonce  input  96  nonce; word j is nonce[32j +: 32].
REQ-009 block_in  input  512  data block written to the engine unchanged.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 error  output  1  poll timeout flag, valid while done is high and held until the next accepted start.
REQ-013 block_out  output  512  engine data output captured during the operation.
REQ-014 tag  output  128  engine tag captured during the operation.
REQ-015 tag_ok  output  1  tag_ok status bit captured at the accepting poll.
REQ-016 bus_cs, bus_we  output  1 each  engine bus strobes.
REQ-017 bus_address  output  8  engine register address.
REQ-018 bus_write_data  output  512  engine write data.
REQ-019 bus_read_data  input  512  engine registered read data, valid the cycle after a read is issued.

Function
REQ-020 Bus outputs SHALL be registered; exactly one bus access SHALL occur per cycle in every non-idle state except POLL_CHK, CAP_TAG and DONE, where bus_cs=0.
REQ-021 In IDLE, start=1 SHALL latch key, nonce, block_in, encdec and key_load, clear error, and enter WR_KEY if key_load=1, otherwise WR_NONCE.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 WR_KEY SHALL write word i to address 0x10+i, for i=0..7 ascending, one per cycle, with the word in bus_write_data[31:0] and upper bits 0.
REQ-024 WR_NONCE SHALL write word j to address 0x20+j, for j=0..2 ascending.
REQ-025 WR_MODE SHALL write {511'b0, encdec} to address 0x0a.
REQ-026 WR_DATA SHALL write block_in to address 0x30.
REQ-027 INIT_SET SHALL write 0x1 to address 0x08; INIT_CLR SHALL then write 0x0 to address 0x08.
REQ-028 POLL_REQ SHALL read address 0x09.
REQ-029 POLL_CHK SHALL sample bus_read_data with bit0=ready, bit1=valid, bit2=tag_ok.
REQ-030 In POLL_CHK, valid=1 SHALL capture tag_ok and go to RD_DATA; valid=0 SHALL increment the poll counter and return to POLL_REQ.
REQ-031 When the poll counter reaches TIMEOUT_POLLS, the block SHALL go to DONE with error=1, leaving block_out, tag and tag_ok unchanged.
REQ-032 RD_DATA SHALL read 0x30; RD_TAG SHALL read 0x40 and capture block_out from bus_read_data; CAP_TAG SHALL capture tag from bus_read_data[127:0].
REQ-033 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-034 busy SHALL equal (state != IDLE).
REQ-035 Latency: with start in cycle 0 and valid on the first poll, done SHALL be high in cycle 21 (key_load=1) or cycle 13 (key_load=0).
REQ-036 Each additional not-valid poll SHALL add 2 cycles of latency.
REQ-037 The poll counter SHALL be 16 bits wide, cleared on start, and SHALL saturate rather than wrap.

Reset
REQ-038 Asserting reset SHALL immediately force state=IDLE and bus_cs=bus_we=0, including mid-operation.
REQ-039 During reset bus_address=0, bus_write_data=0, busy=done=error=tag_ok=0, and block_out and tag are 0.
REQ-040 After reset deasserts, the first start SHALL be accepted normally; no partial operation SHALL resume.

Verification
REQ-041 key=0x00..1f byte ramp, key_load=1, engine model valid on first poll -> writes 0x10..0x17 with word0=0x00010203, then nonce, 0x0a, 0x30, 0x08=1, 0x08=0 in order; done in cycle 21.
REQ-042 key_load=0 -> no access to 0x10..0x17; done in cycle 13.
REQ-043 Model holds valid=0 for 3 polls -> exactly 4 reads of 0x09; done in cycle 27; error=0.
REQ-044 TIMEOUT_POLLS=4 and valid never set -> 4 polls, then done with error=1 and block_out, tag unchanged.
REQ-045 Reset asserted at cycle 10 of an operation -> bus_cs=0 the same cycle and busy=0; a new start completes correctly.
REQ-046 start pulsed while busy -> ignored; only one done pulse and no extra bus writes.
